// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with 16x oversampling and stop-bit error flag
module uart_rx #(
   parameter int FRAME_BITS = 8,
   parameter int OVERSAMPLE = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  os_tick,
   input  logic                  rx_in,
   output logic [FRAME_BITS-1:0] data,
   output logic                  rx_valid,
   output logic                  rx_busy,
   output logic                  frame_err
);

   localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam int BW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
   localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] FULL_M1  = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t                  state_q;
   logic [TW-1:0]           tick_q;
   logic [BW-1:0]           bit_q;
   logic [FRAME_BITS-1:0]   shift_q;
   logic [FRAME_BITS-1:0]   data_q;
   logic                    rx_valid_q;
   logic                    rx_busy_q;
   logic                    frame_err_q;
   logic                    rx_meta_q;
   logic                    rx_s_q;
   logic                    rx_d_q;
   logic [1:0]              warm_q;
   logic                    armed_q;
   logic [FRAME_BITS:0]     shift_d;
   logic                    fall_d;

   assign shift_d = {rx_s_q, shift_q};
   // The synchroniser's reset value is not a real line sample, so a start edge is
   // only accepted once the line has genuinely been seen high after reset.
   assign fall_d  = armed_q & rx_d_q & ~rx_s_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         tick_q      <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         data_q      <= '0;
         rx_valid_q  <= 1'b0;
         rx_busy_q   <= 1'b0;
         frame_err_q <= 1'b0;
         rx_meta_q   <= 1'b1;
         rx_s_q      <= 1'b1;
         rx_d_q      <= 1'b1;
         warm_q      <= 2'b00;
         armed_q     <= 1'b0;
      end else begin
         rx_meta_q   <= rx_in;
         rx_s_q      <= rx_meta_q;
         rx_d_q      <= rx_s_q;
         warm_q      <= {warm_q[0], 1'b1};
         if (warm_q[1] && rx_s_q) begin
            armed_q <= 1'b1;
         end
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;

         case (state_q)
            IDLE: begin
               if (fall_d) begin
                  state_q   <= START;
                  tick_q    <= '0;
                  rx_busy_q <= 1'b1;
               end
            end
            START: begin
               if (os_tick) begin
                  if (tick_q == HALF_M1) begin
                     if (rx_s_q) begin
                        state_q   <= IDLE;
                        rx_busy_q <= 1'b0;
                     end else begin
                        state_q <= DATA;
                        tick_q  <= '0;
                        bit_q   <= '0;
                     end
                  end else begin
                     tick_q <= tick_q + 1'b1;
                  end
               end
            end
            DATA: begin
               if (os_tick) begin
                  if (tick_q == FULL_M1) begin
                     tick_q  <= '0;
                     shift_q <= shift_d[FRAME_BITS:1];
                     if (bit_q == LAST_BIT) begin
                        state_q <= STOP;
                     end else begin
                        bit_q <= bit_q + 1'b1;
                     end
                  end else begin
                     tick_q <= tick_q + 1'b1;
                  end
               end
            end
            STOP: begin
               if (os_tick) begin
                  if (tick_q == FULL_M1) begin
                     if (rx_s_q) begin
                        data_q     <= shift_q;
                        rx_valid_q <= 1'b1;
                     end else begin
                        frame_err_q <= 1'b1;
                     end
                     rx_busy_q <= 1'b0;
                     tick_q    <= '0;
                     state_q   <= IDLE;
                  end else begin
                     tick_q <= tick_q + 1'b1;
                  end
               end
            end
            default: begin
               state_q   <= IDLE;
               rx_busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign data      = data_q;
   assign rx_valid  = rx_valid_q;
   assign rx_busy   = rx_busy_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx
module tb_uart_rx;
   localparam int OS       = 16;
   localparam int DIV      = 4;
   localparam int BIT_CLKS = OS * DIV;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       os_tick = 1'b0;
   logic       rx_in = 1'b1;
   logic [7:0] data;
   logic       rx_valid;
   logic       rx_busy;
   logic       frame_err;

   int         checks = 0;
   int         errors = 0;
   int         valid_cnt = 0;
   int         ferr_cnt = 0;
   int         both_cnt = 0;
   int         div_cnt = 0;
   logic [7:0] last_vdata = 8'h00;
   logic [7:0] model_data = 8'h00;

   uart_rx #(.FRAME_BITS(8), .OVERSAMPLE(OS)) dut (
      .clk(clk), .reset(reset), .os_tick(os_tick), .rx_in(rx_in),
      .data(data), .rx_valid(rx_valid), .rx_busy(rx_busy), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   initial begin
      forever begin
         @(negedge clk);
         os_tick = (div_cnt == DIV - 1);
         div_cnt = (div_cnt + 1) % DIV;
      end
   end

   always @(negedge clk) begin
      if (rx_valid) begin
         valid_cnt  = valid_cnt + 1;
         last_vdata = data;
      end
      if (frame_err) ferr_cnt = ferr_cnt + 1;
      if (rx_valid && frame_err) both_cnt = both_cnt + 1;
   end

   task automatic send_bit(input logic v);
      rx_in = v;
      repeat (BIT_CLKS) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(stop);
   endtask

   task automatic test_reset;
      reset = 1'b0;
      rx_in = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({data, rx_valid, rx_busy, frame_err} !== 11'h0) begin
         errors++;
         $display("FAIL reset_outputs got %h want 000", {data, rx_valid, rx_busy, frame_err});
      end
      reset = 1'b1;
      repeat (BIT_CLKS) @(negedge clk);
      checks++;
      if (rx_busy !== 1'b0 || valid_cnt !== 0) begin
         errors++;
         $display("FAIL reset_idle busy=%b valid_cnt=%0d want 0 0", rx_busy, valid_cnt);
      end
   endtask

   task automatic test_basic;
      logic [7:0] b;
      logic [9:0] bits;
      int v0, f0, busy_low;
      b = 8'hA5;
      bits = {1'b1, b, 1'b0};
      v0 = valid_cnt; f0 = ferr_cnt; busy_low = 0;
      for (int i = 0; i < 10; i++) begin
         rx_in = bits[i];
         repeat (48) @(negedge clk);
         if (i < 9 && rx_busy !== 1'b1) busy_low++;
         repeat (BIT_CLKS - 48) @(negedge clk);
      end
      model_data = b;
      checks++;
      if (busy_low !== 0) begin
         errors++;
         $display("FAIL basic_busy low_samples=%0d want 0", busy_low);
      end
      checks++;
      if (valid_cnt - v0 !== 1 || data !== model_data) begin
         errors++;
         $display("FAIL basic_a5 pulses=%0d data=%h want 1 %h", valid_cnt - v0, data, model_data);
      end
      checks++;
      if (ferr_cnt !== f0 || rx_busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_ferr_busy ferr=%0d busy=%b want %0d 0", ferr_cnt, rx_busy, f0);
      end
   endtask

   task automatic test_extremes;
      logic [7:0] pats [2];
      int v0;
      pats[0] = 8'h00; pats[1] = 8'hFF;
      for (int k = 0; k < 2; k++) begin
         v0 = valid_cnt;
         send_frame(pats[k], 1'b1);
         model_data = pats[k];
         checks++;
         if (valid_cnt - v0 !== 1 || data !== model_data || last_vdata !== model_data) begin
            errors++;
            $display("FAIL extreme_%0d pulses=%0d data=%h want 1 %h", k, valid_cnt - v0, data, model_data);
         end
      end
   endtask

   task automatic test_glitch;
      int v0, f0;
      v0 = valid_cnt; f0 = ferr_cnt;
      rx_in = 1'b0;
      repeat (4 * DIV) @(negedge clk);
      rx_in = 1'b1;
      repeat (BIT_CLKS) @(negedge clk);
      checks++;
      if (valid_cnt !== v0 || ferr_cnt !== f0 || data !== model_data || rx_busy !== 1'b0) begin
         errors++;
         $display("FAIL glitch valid=%0d ferr=%0d data=%h busy=%b want %0d %0d %h 0",
                  valid_cnt, ferr_cnt, data, rx_busy, v0, f0, model_data);
      end
      v0 = valid_cnt;
      send_frame(8'h3C, 1'b1);
      model_data = 8'h3C;
      checks++;
      if (valid_cnt - v0 !== 1 || data !== model_data) begin
         errors++;
         $display("FAIL glitch_after pulses=%0d data=%h want 1 %h", valid_cnt - v0, data, model_data);
      end
   endtask

   task automatic test_frame_err;
      int v0, f0;
      v0 = valid_cnt; f0 = ferr_cnt;
      send_frame(8'h5A, 1'b0);
      checks++;
      if (ferr_cnt - f0 !== 1 || valid_cnt !== v0 || data !== model_data) begin
         errors++;
         $display("FAIL ferr_pulse ferr=%0d valid=%0d data=%h want 1 0 %h",
                  ferr_cnt - f0, valid_cnt - v0, data, model_data);
      end
      repeat (20) send_bit(1'b0);
      checks++;
      if (ferr_cnt - f0 !== 1 || valid_cnt !== v0 || rx_busy !== 1'b0) begin
         errors++;
         $display("FAIL ferr_break ferr=%0d valid=%0d busy=%b want 1 0 0",
                  ferr_cnt - f0, valid_cnt - v0, rx_busy);
      end
      repeat (2) send_bit(1'b1);
      send_frame(8'h81, 1'b1);
      model_data = 8'h81;
      checks++;
      if (valid_cnt - v0 !== 1 || data !== model_data || ferr_cnt - f0 !== 1) begin
         errors++;
         $display("FAIL ferr_recover pulses=%0d data=%h want 1 %h", valid_cnt - v0, data, model_data);
      end
   endtask

   task automatic test_back_to_back;
      int v0;
      logic [7:0] first;
      v0 = valid_cnt;
      send_frame(8'h3C, 1'b1);
      first = last_vdata;
      send_frame(8'hC3, 1'b1);
      model_data = 8'hC3;
      checks++;
      if (valid_cnt - v0 !== 2 || first !== 8'h3C || data !== model_data) begin
         errors++;
         $display("FAIL back_to_back pulses=%0d first=%h data=%h want 2 3c c3", valid_cnt - v0, first, data);
      end
   endtask

   task automatic test_reset_midframe;
      int v0, f0;
      v0 = valid_cnt; f0 = ferr_cnt;
      send_bit(1'b0);
      repeat (3) send_bit(1'b0);
      repeat (20) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({data, rx_valid, rx_busy, frame_err} !== 11'h0) begin
         errors++;
         $display("FAIL midreset_outputs got %h want 000", {data, rx_valid, rx_busy, frame_err});
      end
      repeat (8) @(negedge clk);
      reset = 1'b1;
      model_data = 8'h00;
      repeat (12) send_bit(1'b0);
      checks++;
      if (valid_cnt !== v0 || ferr_cnt !== f0 || rx_busy !== 1'b0 || data !== 8'h00) begin
         errors++;
         $display("FAIL midreset_low valid=%0d ferr=%0d busy=%b data=%h want 0 0 0 00",
                  valid_cnt - v0, ferr_cnt - f0, rx_busy, data);
      end
      repeat (2) send_bit(1'b1);
      send_frame(8'h7E, 1'b1);
      model_data = 8'h7E;
      checks++;
      if (valid_cnt - v0 !== 1 || data !== model_data) begin
         errors++;
         $display("FAIL midreset_after pulses=%0d data=%h want 1 %h", valid_cnt - v0, data, model_data);
      end
   endtask

   task automatic test_random;
      logic [7:0] b;
      logic       stop;
      int         gap, v0, f0;
      for (int n = 0; n < 8; n++) begin
         b    = 8'($urandom);
         stop = ($urandom_range(0, 3) != 0);
         v0 = valid_cnt; f0 = ferr_cnt;
         send_frame(b, stop);
         if (stop) model_data = b;
         checks++;
         if (valid_cnt - v0 !== (stop ? 1 : 0) || ferr_cnt - f0 !== (stop ? 0 : 1) || data !== model_data) begin
            errors++;
            $display("FAIL random_%0d byte=%h stop=%b valid=%0d ferr=%0d data=%h want data %h",
                     n, b, stop, valid_cnt - v0, ferr_cnt - f0, data, model_data);
         end
         gap = $urandom_range(0, 100);
         if (!stop && gap < 4) gap = 4;
         rx_in = 1'b1;
         repeat (gap) @(negedge clk);
      end
   endtask

   task automatic test_exclusive;
      checks++;
      if (both_cnt !== 0) begin
         errors++;
         $display("FAIL valid_ferr_overlap cycles=%0d want 0", both_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_extremes();
      test_glitch();
      test_frame_err();
      test_back_to_back();
      test_reset_midframe();
      test_random();
      test_exclusive();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
